rnd_harvest_ctrl: RTL and testbench

Sequencing controller for the NAND-latch random-bit array. It drives the array's shared gate (0 = random/release, 1 = freeze) through a release/freeze cycle and captures the frozen WIDTH-bit word. It hands each word to one of two requesters under round-robin arbitration. It sits between the latch array and the consumers in the top-level wrapper and replaces the direct pin control of the gate.

---
 rtl/rnd_harvest_pkg.sv | 22 ++
 rtl/rnd_rr_arb2.sv | 41 ++++
 rtl/rnd_harvest_ctrl.sv | 140 ++++++++++++++
 tb/tb_rnd_harvest_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rnd_harvest_pkg.sv
// Shared types and helpers for the NAND-latch random-bit harvest controller.
package rnd_harvest_pkg;

   localparam int unsigned NUM_REQ = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RELEASE = 3'd1,
      FREEZE  = 3'd2,
      SAMPLE  = 3'd3,
      GRANT   = 3'd4
   } harvest_state_e;

   // Phase counter must hold the longest phase length.
   function automatic int unsigned cnt_width(input int unsigned rel_cyc,
                                             input int unsigned frz_cyc);
      int unsigned m;
      m = (rel_cyc > frz_cyc) ? rel_cyc : frz_cyc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rnd_rr_arb2.sv
// Two-requester round-robin arbiter; owns the last-granted pointer (reset to 1).
module rnd_rr_arb2
   import rnd_harvest_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic [NUM_REQ-1:0] req_i,
   output logic [NUM_REQ-1:0] gnt_c_o
);

   logic last_q;
   logic last_d;
   logic [NUM_REQ-1:0] win;

   always_comb begin
      win = '0;
      case (req_i)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = last_q ? 2'b01 : 2'b10;
         default: win = '0;
      endcase
      gnt_c_o = en_i ? win : '0;
      last_d  = last_q;
      if (gnt_c_o[0]) begin
         last_d = 1'b0;
      end else if (gnt_c_o[1]) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/rnd_harvest_ctrl.sv
// Release/freeze sequencer for the latch array, word capture and round-robin hand-off.
// Optional repetition health test compiled in with RNG_HEALTH_EN.
module rnd_harvest_ctrl
   import rnd_harvest_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned RELEASE_CYC = 4,
   parameter int unsigned FREEZE_CYC  = 2,
   parameter int unsigned REP_LIMIT   = 3
) (
   input  logic               clk,
   input  logic               rst,
   output logic               gen_freeze,
   input  logic [WIDTH-1:0]   rnd_bits,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               data_valid,
   output logic [WIDTH-1:0]   data,
   output logic               health_fail
);

   localparam int unsigned CW = cnt_width(RELEASE_CYC, FREEZE_CYC);

   harvest_state_e state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             gen_freeze_q, gen_freeze_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sample_en;
   logic             arb_en;

   // Phase sequencing; counter restarts at 0 on every state entry.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      sample_en = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if ((req != '0) && !health_fail) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (cnt_q == CW'(RELEASE_CYC - 1)) begin
               state_d = FREEZE;
               cnt_d   = '0;
            end
         end
         FREEZE: begin
            if (cnt_q == CW'(FREEZE_CYC - 1)) begin
               state_d = SAMPLE;
               cnt_d   = '0;
            end
         end
         SAMPLE: begin
            cnt_d     = '0;
            sample_en = 1'b1;
            state_d   = GRANT;
         end
         GRANT: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      gen_freeze_d = (state_d != RELEASE);
      data_d       = sample_en ? rnd_bits : data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         gen_freeze_q <= 1'b1;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gen_freeze_q <= gen_freeze_d;
         data_q       <= data_d;
      end
   end

`ifdef RNG_HEALTH_EN
   localparam int unsigned RW = $clog2(REP_LIMIT + 1);

   logic [WIDTH-1:0] prev_q, prev_d;
   logic [RW-1:0]    rep_q, rep_d;
   logic             hf_q, hf_d;

   // Repetition test: consecutive identical samples reaching REP_LIMIT latch a failure.
   always_comb begin
      prev_d = prev_q;
      rep_d  = rep_q;
      hf_d   = hf_q;
      if (sample_en) begin
         prev_d = rnd_bits;
         rep_d  = (rnd_bits == prev_q) ? rep_q + RW'(1) : RW'(1);
         if (rep_d >= RW'(REP_LIMIT)) begin
            hf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
         rep_q  <= '0;
         hf_q   <= 1'b0;
      end else begin
         prev_q <= prev_d;
         rep_q  <= rep_d;
         hf_q   <= hf_d;
      end
   end

   assign health_fail = hf_q;
`else
   assign health_fail = 1'b0;
`endif

   // Winner is chosen in GRANT against the live requests; a failed word is never handed out.
   assign arb_en = (state_q == GRANT) && !health_fail;

   rnd_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .en_i    (arb_en),
      .req_i   (req),
      .gnt_c_o (grant)
   );

   assign data_valid = |grant;
   assign gen_freeze = gen_freeze_q;
   assign data       = data_q;

endmodule

// File: tb/tb_rnd_harvest_ctrl.sv
// Directed bench for rnd_harvest_ctrl with a grant/data scoreboard.
// Health expectations follow RNG_HEALTH_EN.
module tb_rnd_harvest_ctrl;

   logic        clk;
   logic        rst;
   logic        gen_freeze;
   logic [15:0] rnd_bits;
   logic [1:0]  req;
   logic [1:0]  grant;
   logic        data_valid;
   logic [15:0] data;
   logic        health_fail;

   typedef struct packed {
      logic [1:0]  gnt;
      logic [15:0] word;
   } sb_t;

   sb_t sb[$];
   int  errors = 0;
   int  checks = 0;

   rnd_harvest_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .gen_freeze  (gen_freeze),
      .rnd_bits    (rnd_bits),
      .req         (req),
      .grant       (grant),
      .data_valid  (data_valid),
      .data        (data),
      .health_fail (health_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every grant pulse must match the next expected entry.
   always @(negedge clk) begin
      if (grant !== 2'b00 || data_valid !== 1'b0) begin
         if (sb.size() == 0) begin
            chk("unexpected_grant", {29'd0, data_valid, grant}, 32'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            chk("sb_grant", {30'd0, grant}, {30'd0, e.gnt});
            chk("sb_data", {16'd0, data}, {16'd0, e.word});
            chk("sb_dv", {31'd0, data_valid}, 32'd1);
         end
      end
   end

   // One harvest sequence starting in IDLE; returns how many cycles the gate was low.
   task automatic do_word(input logic [1:0] req_v, input logic [15:0] bits,
                          input logic [1:0] exp_gnt, input bit drop, output int low);
      low      = 0;
      req      = req_v;
      rnd_bits = bits;
      if (exp_gnt != 2'b00) sb.push_back('{gnt: exp_gnt, word: bits});
      @(posedge clk);
      if (drop) begin
         #1 req = 2'b00;
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (gen_freeze === 1'b0) low++;
         chk($sformatf("dv_cycle%0d", k), {31'd0, data_valid},
             {31'd0, (k == 8) && (exp_gnt != 2'b00)});
         if (k == 5) chk("freeze_after_release", {31'd0, gen_freeze}, 32'd1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int low;
      rst      = 1'b1;
      req      = 2'b00;
      rnd_bits = 16'h0000;
      do_reset();
      @(negedge clk);
      chk("rst_gen_freeze", {31'd0, gen_freeze}, 32'd1);
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_dv", {31'd0, data_valid}, 32'd0);
      chk("rst_data", {16'd0, data}, 32'd0);
      chk("rst_health", {31'd0, health_fail}, 32'd0);
      @(posedge clk);
      #1;

      // Single requester, fixed pattern, t+8 latency.
      do_word(2'b01, 16'h3C5A, 2'b01, 1'b0, low);
      chk("w1_low_cycles", low, 32'd4);
      req = 2'b00;
      chk("w1_data_hold", {16'd0, data}, 32'h3C5A);

      // Both requesting, back-to-back with a 9-cycle period.
      do_reset();
      do_word(2'b11, 16'h1111, 2'b01, 1'b0, low);
      chk("rr1_low", low, 32'd4);
      do_word(2'b11, 16'h2222, 2'b10, 1'b0, low);
      chk("rr2_low", low, 32'd4);
      do_word(2'b11, 16'h3333, 2'b01, 1'b0, low);
      chk("rr3_low", low, 32'd4);
      req = 2'b00;

      // Request dropped after start: sequence completes, no grant, pointer untouched.
      do_reset();
      do_word(2'b01, 16'h4444, 2'b00, 1'b1, low);
      chk("drop_low", low, 32'd4);
      chk("drop_data", {16'd0, data}, 32'h4444);
      do_word(2'b11, 16'h5555, 2'b01, 1'b0, low);
      chk("after_drop_low", low, 32'd4);
      req = 2'b00;

      // Reset during RELEASE.
      req      = 2'b01;
      rnd_bits = 16'h6666;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_release", {31'd0, gen_freeze}, 32'd0);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_gen_freeze", {31'd0, gen_freeze}, 32'd1);
      chk("midrst_grant", {30'd0, grant}, 32'd0);
      chk("midrst_dv", {31'd0, data_valid}, 32'd0);
      chk("midrst_data", {16'd0, data}, 32'd0);
      repeat (3) @(negedge clk);
      chk("midrst_hold_freeze", {31'd0, gen_freeze}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      req = 2'b00;
      @(posedge clk);
      #1;
      do_word(2'b01, 16'h7777, 2'b01, 1'b0, low);
      chk("post_rst_low", low, 32'd4);

      // Constant pattern against the repetition test.
      do_reset();
      do_word(2'b01, 16'hA5A5, 2'b01, 1'b0, low);
      chk("hc_w1_health", {31'd0, health_fail}, 32'd0);
      do_word(2'b01, 16'hA5A5, 2'b01, 1'b0, low);
      chk("hc_w2_health", {31'd0, health_fail}, 32'd0);
`ifdef RNG_HEALTH_EN
      do_word(2'b01, 16'hA5A5, 2'b00, 1'b0, low);
      chk("hc_w3_low", low, 32'd4);
      chk("hc_w3_health", {31'd0, health_fail}, 32'd1);
      low = 0;
      repeat (20) begin
         @(negedge clk);
         if (gen_freeze === 1'b0) low++;
      end
      chk("hc_stuck_low", low, 32'd0);
      chk("hc_sticky", {31'd0, health_fail}, 32'd1);
`else
      do_word(2'b01, 16'hA5A5, 2'b01, 1'b0, low);
      chk("hc_w3_low", low, 32'd4);
      chk("hc_w3_health", {31'd0, health_fail}, 32'd0);
      do_word(2'b01, 16'hA5A5, 2'b01, 1'b0, low);
      chk("hc_w4_health", {31'd0, health_fail}, 32'd0);
`endif
      req = 2'b00;
      do_reset();
      @(negedge clk);
      chk("final_health", {31'd0, health_fail}, 32'd0);
      chk("sb_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
